// File: rtl/pixel_plot_arbiter.sv
// Two-requester pixel plot arbiter with a full-screen clear sweep, driving a registered VGA pixel port.
// Build option: define PLOT_CLIP_EN to suppress plot for granted pixels outside XRES x YRES.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_ARB   | round-robin arbitration of req0/req1, one pixel per grant
// ST_CLEAR | raster sweep of clear colour, one pixel per cycle, no grants
module pixel_plot_arbiter #(
   parameter int XRES = 160,
   parameter int YRES = 120
) (
   input  logic       CLOCK_50,
   input  logic       Resetn,
   input  logic       req0,
   input  logic       req1,
   input  logic [7:0] x0,
   input  logic [7:0] x1,
   input  logic [6:0] y0,
   input  logic [6:0] y1,
   input  logic [2:0] c0,
   input  logic [2:0] c1,
   output logic       gnt0,
   output logic       gnt1,
   input  logic       clear_start,
   input  logic [2:0] clear_color,
   output logic       clear_busy,
   output logic       clear_done,
   output logic [7:0] VGA_X,
   output logic [6:0] VGA_Y,
   output logic [2:0] VGA_COLOR,
   output logic       plot
);

   localparam logic ST_ARB   = 1'b0;
   localparam logic ST_CLEAR = 1'b1;

   logic       state_q, state_d;
   logic       last_q, last_d;
   logic [7:0] cur_x_q, cur_x_d;
   logic [6:0] cur_y_q, cur_y_d;
   logic [2:0] clr_col_q, clr_col_d;
   logic [7:0] vga_x_q, vga_x_d;
   logic [6:0] vga_y_q, vga_y_d;
   logic [2:0] vga_col_q, vga_col_d;
   logic       plot_q, plot_d;
   logic       done_q, done_d;

   logic       win0, win1;
   logic       grant0, grant1;
   logic [7:0] sel_x;
   logic [6:0] sel_y;
   logic [2:0] sel_c;
   logic       sel_ok;
   logic       last_x, last_y;

   // last_q = 1 means requester 1 won most recently, so requester 0 wins a tie
   assign win0 = req0 & (~req1 | last_q);
   assign win1 = req1 & (~req0 | ~last_q);

   assign grant0 = (state_q == ST_ARB) & ~clear_start & win0;
   assign grant1 = (state_q == ST_ARB) & ~clear_start & win1;

   assign sel_x = grant1 ? x1 : x0;
   assign sel_y = grant1 ? y1 : y0;
   assign sel_c = grant1 ? c1 : c0;

`ifdef PLOT_CLIP_EN
   assign sel_ok = (32'(sel_x) < XRES) && (32'(sel_y) < YRES);
`else
   assign sel_ok = 1'b1;
`endif

   assign last_x = (32'(cur_x_q) == XRES - 1);
   assign last_y = (32'(cur_y_q) == YRES - 1);

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      cur_x_d   = cur_x_q;
      cur_y_d   = cur_y_q;
      clr_col_d = clr_col_q;
      vga_x_d   = vga_x_q;
      vga_y_d   = vga_y_q;
      vga_col_d = vga_col_q;
      plot_d    = 1'b0;
      done_d    = 1'b0;

      case (state_q)
         ST_ARB: begin
            if (clear_start) begin
               state_d   = ST_CLEAR;
               clr_col_d = clear_color;
               cur_x_d   = 8'd0;
               cur_y_d   = 7'd0;
            end else if (grant0 | grant1) begin
               last_d    = grant1;
               vga_x_d   = sel_x;
               vga_y_d   = sel_y;
               vga_col_d = sel_c;
               plot_d    = sel_ok;
            end
         end
         ST_CLEAR: begin
            vga_x_d   = cur_x_q;
            vga_y_d   = cur_y_q;
            vga_col_d = clr_col_q;
            plot_d    = 1'b1;
            if (last_x) begin
               cur_x_d = 8'd0;
               if (last_y) begin
                  cur_y_d = 7'd0;
                  state_d = ST_ARB;
                  done_d  = 1'b1;
               end else begin
                  cur_y_d = cur_y_q + 7'd1;
               end
            end else begin
               cur_x_d = cur_x_q + 8'd1;
            end
         end
         default: state_d = ST_ARB;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         state_q   <= ST_ARB;
         last_q    <= 1'b1;
         cur_x_q   <= 8'd0;
         cur_y_q   <= 7'd0;
         clr_col_q <= 3'd0;
         vga_x_q   <= 8'd0;
         vga_y_q   <= 7'd0;
         vga_col_q <= 3'd0;
         plot_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         cur_x_q   <= cur_x_d;
         cur_y_q   <= cur_y_d;
         clr_col_q <= clr_col_d;
         vga_x_q   <= vga_x_d;
         vga_y_q   <= vga_y_d;
         vga_col_q <= vga_col_d;
         plot_q    <= plot_d;
         done_q    <= done_d;
      end
   end

   // grants are combinational, so they must also be masked by reset directly
   assign gnt0       = grant0 & Resetn;
   assign gnt1       = grant1 & Resetn;
   assign clear_busy = (state_q == ST_CLEAR);
   assign clear_done = done_q;
   assign VGA_X      = vga_x_q;
   assign VGA_Y      = vga_y_q;
   assign VGA_COLOR  = vga_col_q;
   assign plot       = plot_q;

endmodule

// File: tb/tb_pixel_plot_arbiter.sv
// Bench for pixel_plot_arbiter: vector table, clear/reset sequences, then random traffic vs. a raster-index model.
module tb_pixel_plot_arbiter;
   localparam int XR = 4;
   localparam int YR = 3;
`ifdef PLOT_CLIP_EN
   localparam bit CLIP = 1'b1;
`else
   localparam bit CLIP = 1'b0;
`endif

   logic       CLOCK_50, Resetn;
   logic       req0, req1, gnt0, gnt1;
   logic [7:0] x0, x1, VGA_X;
   logic [6:0] y0, y1, VGA_Y;
   logic [2:0] c0, c1, VGA_COLOR, clear_color;
   logic       clear_start, clear_busy, clear_done, plot;

   pixel_plot_arbiter #(.XRES(XR), .YRES(YR)) dut (
      .CLOCK_50(CLOCK_50), .Resetn(Resetn),
      .req0(req0), .req1(req1), .x0(x0), .x1(x1), .y0(y0), .y1(y1), .c0(c0), .c1(c1),
      .gnt0(gnt0), .gnt1(gnt1), .clear_start(clear_start), .clear_color(clear_color),
      .clear_busy(clear_busy), .clear_done(clear_done),
      .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOR(VGA_COLOR), .plot(plot)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: clear progress is a linear raster index, arbitration is "who won last"
   bit   m_clear;
   int   m_idx;
   int   m_last;
   int   m_col;
   bit   m_g0, m_g1;
   int   e_x, e_y, e_c;
   bit   e_plot, e_busy, e_done;

   task automatic model_reset();
      m_clear = 0; m_idx = 0; m_last = 1; m_col = 0;
      m_g0 = 0; m_g1 = 0;
      e_x = 0; e_y = 0; e_c = 0; e_plot = 0; e_busy = 0; e_done = 0;
   endtask

   task automatic model_step();
      int w;
      m_g0 = 0; m_g1 = 0; e_done = 0;
      if (!m_clear) begin
         e_plot = 0;
         if (clear_start) begin
            m_clear = 1; m_idx = 0; m_col = int'(clear_color);
         end else if (req0 || req1) begin
            if (req0 && req1) w = 1 - m_last;
            else w = req0 ? 0 : 1;
            m_last = w;
            if (w == 0) begin
               m_g0 = 1; e_x = int'(x0); e_y = int'(y0); e_c = int'(c0);
            end else begin
               m_g1 = 1; e_x = int'(x1); e_y = int'(y1); e_c = int'(c1);
            end
            e_plot = CLIP ? (e_x < XR && e_y < YR) : 1'b1;
         end
      end else begin
         e_x = m_idx % XR; e_y = m_idx / XR; e_c = m_col; e_plot = 1;
         if (m_idx == XR * YR - 1) begin
            m_clear = 0; e_done = 1;
         end else begin
            m_idx++;
         end
      end
      e_busy = m_clear;
   endtask

   // called at a negedge with inputs already applied; returns at the next negedge
   task automatic step_model(input string tag);
      model_step();
      #1;
      chk({tag, " gnt0"}, int'(gnt0), int'(m_g0));
      chk({tag, " gnt1"}, int'(gnt1), int'(m_g1));
      @(posedge CLOCK_50); #1;
      chk({tag, " plot"}, int'(plot), int'(e_plot));
      chk({tag, " busy"}, int'(clear_busy), int'(e_busy));
      chk({tag, " done"}, int'(clear_done), int'(e_done));
      if (e_plot) begin
         chk({tag, " x"}, int'(VGA_X), e_x);
         chk({tag, " y"}, int'(VGA_Y), e_y);
         chk({tag, " c"}, int'(VGA_COLOR), e_c);
      end
      @(negedge CLOCK_50);
   endtask

   typedef struct {
      bit r0, r1;
      int x0, y0, c0, x1, y1, c1;
      bit g0, g1, p;
      int ex, ey, ec;
   } vec_t;
   vec_t tbl[10];

   task automatic idle_inputs();
      req0 = 0; req1 = 0; clear_start = 0; clear_color = 0;
      x0 = 0; y0 = 0; c0 = 0; x1 = 0; y1 = 0; c1 = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      Resetn = 0;
      repeat (2) @(negedge CLOCK_50);
      Resetn = 1;
      model_reset();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      bit pend0, pend1;
      tbl[0] = '{1, 1, 10, 20, 1, 30, 40, 6, 1, 0, 1, 10, 20, 1};
      tbl[1] = '{1, 1, 10, 20, 1, 30, 40, 6, 0, 1, 1, 30, 40, 6};
      tbl[2] = '{1, 1, 10, 20, 1, 30, 40, 6, 1, 0, 1, 10, 20, 1};
      tbl[3] = '{1, 1, 10, 20, 1, 30, 40, 6, 0, 1, 1, 30, 40, 6};
      tbl[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 30, 40, 6};
      tbl[5] = '{1, 0, 5, 7, 3, 0, 0, 0, 1, 0, 1, 5, 7, 3};
      tbl[6] = '{0, 1, 0, 0, 0, 1, 2, 7, 0, 1, 1, 1, 2, 7};
      tbl[7] = '{0, 1, 0, 0, 0, 2, 2, 7, 0, 1, 1, 2, 2, 7};
      tbl[8] = '{1, 1, 200, 10, 4, 3, 3, 3, 1, 0, !CLIP, 200, 10, 4};
      tbl[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 200, 10, 4};

      // reset state, with a request held so gnt masking is visible
      idle_inputs();
      Resetn = 0;
      req0 = 1; req1 = 1;
      #2;
      chk("rst gnt0", int'(gnt0), 0);
      chk("rst gnt1", int'(gnt1), 0);
      chk("rst plot", int'(plot), 0);
      chk("rst busy", int'(clear_busy), 0);
      chk("rst done", int'(clear_done), 0);
      chk("rst vga", int'({VGA_X, VGA_Y, VGA_COLOR}), 0);
      repeat (2) @(negedge CLOCK_50);
      Resetn = 1;

      foreach (tbl[i]) begin
         req0 = tbl[i].r0; req1 = tbl[i].r1;
         x0 = 8'(tbl[i].x0); y0 = 7'(tbl[i].y0); c0 = 3'(tbl[i].c0);
         x1 = 8'(tbl[i].x1); y1 = 7'(tbl[i].y1); c1 = 3'(tbl[i].c1);
         #1;
         chk($sformatf("vec%0d gnt0", i), int'(gnt0), int'(tbl[i].g0));
         chk($sformatf("vec%0d gnt1", i), int'(gnt1), int'(tbl[i].g1));
         @(posedge CLOCK_50); #1;
         chk($sformatf("vec%0d plot", i), int'(plot), int'(tbl[i].p));
         chk($sformatf("vec%0d x", i), int'(VGA_X), tbl[i].ex);
         chk($sformatf("vec%0d y", i), int'(VGA_Y), tbl[i].ey);
         chk($sformatf("vec%0d c", i), int'(VGA_COLOR), tbl[i].ec);
         @(negedge CLOCK_50);
      end

      // full clear with both requesters waiting; last winner was 0, so 1 must win after
      req0 = 1; x0 = 9; y0 = 9; c0 = 1;
      req1 = 1; x1 = 11; y1 = 12; c1 = 6;
      clear_start = 1; clear_color = 2;
      #1;
      chk("clr start gnt0", int'(gnt0), 0);
      chk("clr start gnt1", int'(gnt1), 0);
      @(posedge CLOCK_50); #1;
      chk("clr start busy", int'(clear_busy), 1);
      chk("clr start plot", int'(plot), 0);
      @(negedge CLOCK_50);
      clear_start = 0;
      for (int k = 0; k < XR * YR; k++) begin
         if (k == 4) begin
            clear_start = 1; clear_color = 5;
         end
         #1;
         chk($sformatf("clr%0d gnt", k), int'({gnt0, gnt1}), 0);
         @(posedge CLOCK_50); #1;
         chk($sformatf("clr%0d plot", k), int'(plot), 1);
         chk($sformatf("clr%0d x", k), int'(VGA_X), k % XR);
         chk($sformatf("clr%0d y", k), int'(VGA_Y), k / XR);
         chk($sformatf("clr%0d c", k), int'(VGA_COLOR), 2);
         chk($sformatf("clr%0d busy", k), int'(clear_busy), (k == XR * YR - 1) ? 0 : 1);
         chk($sformatf("clr%0d done", k), int'(clear_done), (k == XR * YR - 1) ? 1 : 0);
         @(negedge CLOCK_50);
         clear_start = 0;
      end
      #1;
      chk("post clr gnt0", int'(gnt0), 0);
      chk("post clr gnt1", int'(gnt1), 1);
      @(posedge CLOCK_50); #1;
      chk("post clr done", int'(clear_done), 0);
      chk("post clr plot", int'(plot), 1);
      chk("post clr x", int'(VGA_X), 11);
      @(negedge CLOCK_50);

      // reset in the middle of a sweep
      idle_inputs();
      clear_start = 1; clear_color = 7;
      @(negedge CLOCK_50);
      clear_start = 0;
      repeat (5) @(posedge CLOCK_50);
      #1;
      chk("midrst pre plot", int'(plot), 1);
      chk("midrst pre x", int'(VGA_X), 0);
      chk("midrst pre y", int'(VGA_Y), 1);
      @(negedge CLOCK_50);
      req0 = 1;
      Resetn = 0;
      #1;
      chk("midrst plot", int'(plot), 0);
      chk("midrst busy", int'(clear_busy), 0);
      chk("midrst done", int'(clear_done), 0);
      chk("midrst vga", int'({VGA_X, VGA_Y, VGA_COLOR}), 0);
      chk("midrst gnt0", int'(gnt0), 0);
      repeat (2) @(negedge CLOCK_50);
      Resetn = 1;
      req0 = 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge CLOCK_50); #1;
         chk($sformatf("after rst%0d plot", k), int'(plot), 0);
         chk($sformatf("after rst%0d done", k), int'(clear_done), 0);
         chk($sformatf("after rst%0d busy", k), int'(clear_busy), 0);
      end
      @(negedge CLOCK_50);
      req1 = 1; x1 = 3; y1 = 1; c1 = 5;
      #1;
      chk("after rst gnt1", int'(gnt1), 1);
      @(posedge CLOCK_50); #1;
      chk("after rst plot", int'(plot), 1);
      chk("after rst x", int'(VGA_X), 3);
      @(negedge CLOCK_50);

      // random traffic against the model; ungranted requests hold their data
      do_reset();
      pend0 = 0; pend1 = 0;
      for (int n = 0; n < 600; n++) begin
         if (!pend0) begin
            req0 = 1'($urandom_range(0, 1));
            x0 = 8'($urandom_range(0, 255)); y0 = 7'($urandom_range(0, 127)); c0 = 3'($urandom_range(0, 7));
         end
         if (!pend1) begin
            req1 = 1'($urandom_range(0, 1));
            x1 = 8'($urandom_range(0, 255)); y1 = 7'($urandom_range(0, 127)); c1 = 3'($urandom_range(0, 7));
         end
         clear_start = ($urandom_range(0, 24) == 0);
         clear_color = 3'($urandom_range(0, 7));
         step_model($sformatf("rnd%0d", n));
         pend0 = req0 && !m_g0;
         pend1 = req1 && !m_g1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
